rip_pseudo_core_v2: RTL
=======================

RIP_PSEUDO_CORE_V2 -- requirements
Module: rip_pseudo_core_v2

Interface
- REQ-001 ADDR_WIDTH, 32, AXI address width.
- REQ-002 AXI_DATA_WIDTH, 32, beat width; must be 32 or 64.
- REQ-003 BURST_LEN, 16, beats per burst; range 1..256.
- REQ-004 NUM_BURSTS, 4, bursts per run; range 1..65535.
- REQ-005 clk  in  1  sole clock; all logic on rising edge.
- REQ-006 rst  in  1  reset, asynchronous, active-high.
- REQ-007 start  in  1  run request; sampled only in IDLE.
- REQ-008 mem_head  in  ADDR_WIDTH  region base; latched at accepted start.
- REQ-009 seed  in  AXI_DATA_WIDTH  pattern seed; latched at accepted start.
- REQ-010 busy  out  2  bit0 write phase active, bit1 read phase active.
- REQ-011 done  out  1  one-cycle pulse at run end.
- REQ-012 err_count  out  16  read-back mismatch count, saturating.
- REQ-013 AWADDR  out  ADDR_WIDTH; AWLEN out 8; AWVALID out 1; AWREADY in 1.
- REQ-014 WDATA  out  AXI_DATA_WIDTH; WLAST out 1; WVALID out 1; WREADY in 1.
- REQ-015 BVALID  in  1; BREADY out 1.
- REQ-016 ARADDR  out  ADDR_WIDTH; ARLEN out 8; ARVALID out 1; ARREADY in 1.
- REQ-017 RDATA  in  AXI_DATA_WIDTH; RLAST in 1; RVALID in 1; RREADY out 1.
- REQ-018 IDs, WSTRB (all ones), SIZE, BURST (INCR), cache/prot/qos/region are constant and tied off by the integration wrapper; BRESP/RRESP are ignored.

Function
- REQ-019 FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE; start in IDLE -> WR_ADDR; start in any other state is ignored.
- REQ-020 Beat k (0..BURST_LEN*NUM_BURSTS-1) carries seed+k modulo 2^AXI_DATA_WIDTH; burst b address = mem_head + b*BURST_LEN*(AXI_DATA_WIDTH/8), wrapping modulo 2^ADDR_WIDTH.
- REQ-021 AWLEN = ARLEN = BURST_LEN-1; exactly one burst outstanding; no AW/W overlap.
- REQ-022 VALID asserted is held with stable payload until its READY handshake; never retracted.
- REQ-023 WR_ADDR -> WR_DATA on AW handshake; WR_DATA: WVALID=1, WLAST on beat BURST_LEN-1, -> WR_RESP after last-beat handshake; WR_RESP: BREADY=1, on BVALID -> WR_ADDR for next burst, or next phase after burst NUM_BURSTS-1.
- REQ-024 RD_ADDR -> RD_DATA on AR handshake; RD_DATA: RREADY=1, each accepted beat compared to expected; mismatch increments err_count, saturating at 0xFFFF; RLAST handshake -> RD_ADDR or DONE after last burst.
- REQ-025 A premature or missing RLAST does not affect the beat counter; burst end is decided by internal count of BURST_LEN beats.
- REQ-026 DONE lasts one cycle with done=1, then IDLE; err_count holds until next accepted start, which clears it.
- REQ-027 busy[0]=1 in WR_*; busy[1]=1 in RD_*; else 0.

Reset
- REQ-028 rst asserted at any time, including mid-burst, forces IDLE and drives all VALID/READY, done, busy, err_count, AWADDR/ARADDR, AWLEN/ARLEN, WDATA, WLAST to 0 asynchronously; no burst is completed.

Configuration
- REQ-029 RIP_PSEUDO_CORE_READBACK_EN defined: read phase present per REQ-024; undefined: WR_RESP of last burst -> DONE, RD_* states absent, ARVALID/RREADY/ARADDR/ARLEN constant 0, err_count constant 0, busy[1] constant 0.

Verification
- REQ-030 Defaults, mem_head=0x1000, seed=0, zero-wait slave -> 4 AW at 0x1000/0x1040/0x1080/0x10C0, AWLEN=15, 64 beats 0..63, WLAST every 16th, done once, err_count=0.
- REQ-031 Slave corrupts read beat 5 of burst 2 -> err_count=1; memory model shows correct data.
- REQ-032 Random READY/BVALID/RVALID stalls -> no VALID drops, payload stable, data order identical to REQ-030.
- REQ-033 seed=0xFFFFFFFE -> beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, ...; mem_head=0xFFFFFFC0 -> burst 1 address 0x00000000.
- REQ-034 rst pulsed during WR_DATA beat 7 -> all outputs 0 same cycle, busy=0; new start runs full sequence cleanly; start pulses while busy ignored.
- REQ-035 Macro undefined -> no AR traffic, done one cycle after last BVALID, busy[1]=0 throughout.

Source files
------------

// File: rtl/rip_pseudo_core_v2.sv
// rip_pseudo_core_v2 -- AXI memory pattern exerciser.
//
// On an accepted start the core writes NUM_BURSTS incrementing bursts of
// BURST_LEN beats to the region at mem_head. Beat k carries seed+k. With
// RIP_PSEUDO_CORE_READBACK_EN defined, it then reads the region back and counts
// beats that differ from the expected pattern. Without the macro, the run ends
// after the last write response and the read channel is held idle.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               run request, only honoured in IDLE
//   mem_head, seed      region base / pattern seed, latched at accepted start
//   busy[1:0]           bit0 write phase, bit1 read phase
//   done                one-cycle pulse at end of run
//   err_count           saturating read-back mismatch count
//   AW*/W*/B*           AXI write address, data and response channels
//   AR*/R*              AXI read address and data channels
//
// Configuration macro: RIP_PSEUDO_CORE_READBACK_EN (read-back phase present)

module rip_pseudo_core_v2 #(
   parameter int ADDR_WIDTH     = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int BURST_LEN      = 16,
   parameter int NUM_BURSTS     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [ADDR_WIDTH-1:0]     mem_head,
   input  logic [AXI_DATA_WIDTH-1:0] seed,
   output logic [1:0]                busy,
   output logic                      done,
   output logic [15:0]               err_count,
   output logic [ADDR_WIDTH-1:0]     AWADDR,
   output logic [7:0]                AWLEN,
   output logic                      AWVALID,
   input  logic                      AWREADY,
   output logic [AXI_DATA_WIDTH-1:0] WDATA,
   output logic                      WLAST,
   output logic                      WVALID,
   input  logic                      WREADY,
   input  logic                      BVALID,
   output logic                      BREADY,
   output logic [ADDR_WIDTH-1:0]     ARADDR,
   output logic [7:0]                ARLEN,
   output logic                      ARVALID,
   input  logic                      ARREADY,
   input  logic [AXI_DATA_WIDTH-1:0] RDATA,
   input  logic                      RLAST,
   input  logic                      RVALID,
   output logic                      RREADY
);

   localparam int                      BYTES_PER_BEAT = AXI_DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0]   BURST_BYTES    = ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);
   localparam logic [8:0]              BEAT_LAST      = 9'(BURST_LEN - 1);
   localparam logic [15:0]             BURST_LAST     = 16'(NUM_BURSTS - 1);
   localparam logic [7:0]              AXLEN          = 8'(BURST_LEN - 1);
   localparam logic [AXI_DATA_WIDTH-1:0] DATA_ONE     = AXI_DATA_WIDTH'(1);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
   } state_t;

   state_t                      state, state_nxt;
   logic [ADDR_WIDTH-1:0]       addr_q;
   logic [AXI_DATA_WIDTH-1:0]   wdata_q;
   logic [8:0]                  beat_q;
   logic [15:0]                 burst_q;
   logic                        beat_last;
   logic                        burst_last;

   assign beat_last  = (beat_q == BEAT_LAST);
   assign burst_last = (burst_q == BURST_LAST);

   assign AWADDR = addr_q;
   assign WDATA  = wdata_q;

`ifdef RIP_PSEUDO_CORE_READBACK_EN
   logic [ADDR_WIDTH-1:0]       head_q;
   logic [AXI_DATA_WIDTH-1:0]   exp_q;
   logic [15:0]                 err_q;
   logic                        unused_ok;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign ARADDR    = addr_q;
   assign err_count = err_q;
   // Burst end is decided by the internal beat count, RLAST is not trusted.
   assign unused_ok = RLAST;
`else
   logic                        unused_ok;

   assign ARADDR    = '0;
   assign err_count = '0;
   assign unused_ok = ^{ARREADY, RDATA, RLAST, RVALID};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and channel controls; every VALID is a pure state decode so
   // it can only fall on the state change caused by its own handshake.
   always_comb begin
      state_nxt = state;
      busy      = 2'b00;
      done      = 1'b0;
      AWVALID   = 1'b0;
      AWLEN     = 8'd0;
      WVALID    = 1'b0;
      WLAST     = 1'b0;
      BREADY    = 1'b0;
      ARVALID   = 1'b0;
      ARLEN     = 8'd0;
      RREADY    = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = WR_ADDR;
         end
         WR_ADDR: begin
            busy[0] = 1'b1;
            AWVALID = 1'b1;
            AWLEN   = AXLEN;
            if (AWREADY) state_nxt = WR_DATA;
         end
         WR_DATA: begin
            busy[0] = 1'b1;
            WVALID  = 1'b1;
            WLAST   = beat_last;
            if (WREADY && beat_last) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            busy[0] = 1'b1;
            BREADY  = 1'b1;
            if (BVALID) begin
`ifdef RIP_PSEUDO_CORE_READBACK_EN
               state_nxt = burst_last ? RD_ADDR : WR_ADDR;
`else
               state_nxt = burst_last ? DONE : WR_ADDR;
`endif
            end
         end
`ifdef RIP_PSEUDO_CORE_READBACK_EN
         RD_ADDR: begin
            busy[1] = 1'b1;
            ARVALID = 1'b1;
            ARLEN   = AXLEN;
            if (ARREADY) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            busy[1] = 1'b1;
            RREADY  = 1'b1;
            if (RVALID && beat_last) state_nxt = burst_last ? DONE : RD_ADDR;
         end
`endif
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Address, pattern and counters. Everything advances only on a handshake
   // so payloads stay stable while VALID waits for READY.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         beat_q  <= '0;
         burst_q <= '0;
`ifdef RIP_PSEUDO_CORE_READBACK_EN
         head_q  <= '0;
         exp_q   <= '0;
         err_q   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q  <= mem_head;
                  wdata_q <= seed;
                  beat_q  <= '0;
                  burst_q <= '0;
`ifdef RIP_PSEUDO_CORE_READBACK_EN
                  head_q  <= mem_head;
                  exp_q   <= seed;
                  err_q   <= '0;
`endif
               end
            end
            WR_DATA: begin
               if (WREADY) begin
                  wdata_q <= wdata_q + DATA_ONE;
                  beat_q  <= beat_last ? 9'd0 : beat_q + 9'd1;
               end
            end
            WR_RESP: begin
               if (BVALID) begin
                  if (burst_last) begin
                     burst_q <= '0;
`ifdef RIP_PSEUDO_CORE_READBACK_EN
                     addr_q  <= head_q;
`endif
                  end else begin
                     burst_q <= burst_q + 16'd1;
                     addr_q  <= addr_q + BURST_BYTES;
                  end
               end
            end
`ifdef RIP_PSEUDO_CORE_READBACK_EN
            RD_DATA: begin
               if (RVALID) begin
                  exp_q <= exp_q + DATA_ONE;
                  if (RDATA != exp_q) err_q <= sat_inc(err_q);
                  if (beat_last) begin
                     beat_q <= '0;
                     if (!burst_last) begin
                        burst_q <= burst_q + 16'd1;
                        addr_q  <= addr_q + BURST_BYTES;
                     end
                  end else begin
                     beat_q <= beat_q + 9'd1;
                  end
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule
